// File: rtl/cmp_mon_pkg.sv
// rtl/cmp_mon_pkg.sv - relation encodings and debounce limits shared by the comparator result monitor
package cmp_mon_pkg;

  // Committed relation encoding, bit order {gt,eq,lt}
  typedef enum logic [2:0] {
    ST_NONE  = 3'b000,
    ST_LT    = 3'b001,
    ST_EQ    = 3'b010,
    ST_GT    = 3'b100,
    ST_FAULT = 3'b111
  } rel_e;

  localparam int DEBOUNCE_MIN = 1;
  localparam int DEBOUNCE_MAX = 15;
  // Run counter wide enough to hold DEBOUNCE_MAX
  localparam int RUN_W = 4;

  // True for the three one-hot patterns a healthy comparator can produce
  function automatic logic is_relation(input logic [2:0] s);
    return (s == ST_LT) || (s == ST_EQ) || (s == ST_GT);
  endfunction

endpackage

// File: rtl/cmp_debounce.sv
// rtl/cmp_debounce.sv - candidate register and run counter producing a debounced commit strobe
module cmp_debounce
  import cmp_mon_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [2:0] sample,
  input  logic       clear,
  input  logic [2:0] mon_state,
  output logic       commit,
  output logic [2:0] commit_rel
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [2:0]       cand;
  logic [RUN_W-1:0] run;
  logic [2:0]       cand_next;
  logic [RUN_W-1:0] run_next;

  // Next candidate/run: same relation extends the run (saturating), a new one restarts it
  always_comb begin
    cand_next = cand;
    run_next  = run;
    if (sample_valid) begin
      if (sample == cand) begin
        run_next = (run == RUN_MAX) ? run : run + RUN_ONE;
      end else begin
        cand_next = sample;
        run_next  = RUN_ONE;
      end
    end
  end

  // Commit fires on the accepting edge; a relation already committed never re-fires
  assign commit     = sample_valid && (run_next == RUN_MAX) && (cand_next != mon_state);
  assign commit_rel = cand_next;

  // Candidate and run counter; clear is used when a fault forces a fresh start
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cand <= ST_NONE;
      run  <= '0;
    end else begin
      cand <= cand_next;
      run  <= run_next;
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - debounced comparator relation monitor with one-entry event buffer (optional CMP_MON_FAULT_EN)
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic [2:0]       mon_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_from,
  output logic [2:0]       evt_to,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_ovf
);

  logic [2:0] sample;
  logic       rel_ok;
  logic       fault_hit;
  logic       commit;
  logic [2:0] commit_rel;
  logic       new_evt;
  logic [2:0] new_to;

  assign sample = {gt, eq, lt};
  assign rel_ok = is_relation(sample);

`ifdef CMP_MON_FAULT_EN
  // Any non one-hot sample is an immediate fault, no debounce
  assign fault_hit = in_valid && !rel_ok;
`else
  // Invalid samples are treated exactly like idle cycles
  assign fault_hit = 1'b0;
`endif

  cmp_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (in_valid && rel_ok),
    .sample       (sample),
    .clear        (fault_hit),
    .mon_state    (mon_state),
    .commit       (commit),
    .commit_rel   (commit_rel)
  );

  assign new_evt = fault_hit ? (mon_state != ST_FAULT) : commit;
  assign new_to  = fault_hit ? ST_FAULT : commit_rel;

  // Committed state, saturating counter, and the one-deep event buffer with sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      mon_state <= ST_NONE;
      evt_valid <= 1'b0;
      evt_from  <= ST_NONE;
      evt_to    <= ST_NONE;
      evt_cnt   <= '0;
      evt_ovf   <= 1'b0;
    end else if (new_evt) begin
      mon_state <= new_to;
      if (evt_cnt != {CNT_W{1'b1}}) begin
        evt_cnt <= evt_cnt + 1'b1;
      end
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_from  <= mon_state;
        evt_to    <= new_to;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - scoreboard bench for cmp_result_monitor with history-based reference model
module tb_cmp_result_monitor;

  localparam int DEB  = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          lt = 1'b0;
  logic          eq = 1'b0;
  logic          gt = 1'b0;
  logic          evt_ready = 1'b0;
  logic [2:0]    mon_state;
  logic          evt_valid;
  logic [2:0]    evt_from;
  logic [2:0]    evt_to;
  logic [CW-1:0] evt_cnt;
  logic          evt_ovf;

  int n_checks = 0;
  int n_err    = 0;

  cmp_result_monitor #(
    .DEBOUNCE (DEB),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .mon_state (mon_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_from  (evt_from),
    .evt_to    (evt_to),
    .evt_cnt   (evt_cnt),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a relation commits when the last DEB valid samples agree and differ from the state
  int         hist[$];
  logic [5:0] exp_q[$];
  int         m_state = 0;
  bit         m_full  = 0;
  int         m_cnt   = 0;
  bit         m_ovf   = 0;
  bit         started = 0;

  function automatic bit is_rel(input int s);
    return (s == 1) || (s == 2) || (s == 4);
  endfunction

  always @(posedge clk) begin
    int s;
    int to;
    bit ev;
    bit same;
    s  = int'({gt, eq, lt});
    ev = 0;
    to = 0;
    if (rst) begin
      hist.delete();
      exp_q.delete();
      m_state = 0;
      m_full  = 0;
      m_cnt   = 0;
      m_ovf   = 0;
      started = 1;
    end else begin
      if (in_valid && is_rel(s)) begin
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        same = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != s) same = 0;
        if (same && s != m_state) begin
          ev = 1;
          to = s;
        end
      end
`ifdef CMP_MON_FAULT_EN
      else if (in_valid) begin
        hist.delete();
        if (m_state != 7) begin
          ev = 1;
          to = 7;
        end
      end
`endif
      if (ev) begin
        if (!m_full || evt_ready) begin
          exp_q.push_back({3'(m_state), 3'(to)});
          m_full = 1;
        end else begin
          m_ovf = 1;
        end
        m_state = to;
        if (m_cnt < CMAX) m_cnt++;
      end else if (m_full && evt_ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: compare presented outputs against the model; consume the event on handshake
  always @(negedge clk) begin
    if (started) begin
      chk("mon_state", 32'(mon_state), 32'(m_state));
      chk("evt_valid", 32'(evt_valid), 32'(m_full));
      chk("evt_cnt", 32'(evt_cnt), 32'(m_cnt));
      chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
      if (m_full && exp_q.size() > 0) begin
        chk("evt_from", 32'(evt_from), 32'(exp_q[0][5:3]));
        chk("evt_to", 32'(evt_to), 32'(exp_q[0][2:0]));
        if (evt_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit r, input bit v, input logic [2:0] s, input bit rdy);
    @(posedge clk);
    #2;
    rst       = r;
    in_valid  = v;
    {gt, eq, lt} = s;
    evt_ready = rdy;
  endtask

  task automatic burst(input logic [2:0] s, input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 1, s, rdy);
  endtask

  initial begin
    logic [2:0] last;
    logic [2:0] s;
    logic [2:0] rels[3];
    logic [2:0] bads[5];
    rels = '{3'b001, 3'b010, 3'b100};
    bads = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    // Reset state
    drive(1, 0, 3'b000, 0);
    drive(1, 0, 3'b000, 0);
    drive(0, 0, 3'b000, 0);
    chk("rst_state", 32'(mon_state), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_from", 32'(evt_from), 0);
    chk("rst_to", 32'(evt_to), 0);
    chk("rst_cnt", 32'(evt_cnt), 0);

    // Three LT samples commit LT
    burst(3'b001, 3, 0);
    drive(0, 0, 3'b000, 0);
    chk("lt_state", 32'(mon_state), 1);
    chk("lt_evt_to", 32'(evt_to), 1);
    chk("lt_cnt", 32'(evt_cnt), 1);
    drive(0, 0, 3'b000, 1);

    // An EQ in the middle restarts the GT run
    burst(3'b100, 2, 1);
    burst(3'b010, 1, 1);
    burst(3'b100, 3, 1);
    drive(0, 0, 3'b000, 1);
    chk("gt_state", 32'(mon_state), 4);
    chk("gt_cnt", 32'(evt_cnt), 2);

    // Overflow with a stalled consumer
    drive(1, 0, 3'b000, 0);
    burst(3'b001, 3, 0);
    burst(3'b010, 3, 0);
    drive(0, 0, 3'b000, 0);
    chk("ovf_from", 32'(evt_from), 0);
    chk("ovf_to", 32'(evt_to), 1);
    chk("ovf_flag", 32'(evt_ovf), 1);
    chk("ovf_cnt", 32'(evt_cnt), 2);
    chk("ovf_state", 32'(mon_state), 2);

    // Reset wins over a pending event and a live sample
    drive(1, 1, 3'b100, 0);
    drive(0, 0, 3'b000, 0);
    chk("rst2_valid", 32'(evt_valid), 0);
    chk("rst2_state", 32'(mon_state), 0);
    chk("rst2_to", 32'(evt_to), 0);
    chk("rst2_ovf", 32'(evt_ovf), 0);

    // Invalid sample
    drive(0, 1, 3'b011, 1);
    drive(0, 0, 3'b000, 1);
`ifdef CMP_MON_FAULT_EN
    chk("fault_state", 32'(mon_state), 7);
`else
    chk("invalid_state", 32'(mon_state), 0);
`endif

    // Counter saturation across five alternating commits
    for (int k = 0; k < 5; k++) burst((k % 2 == 0) ? 3'b001 : 3'b010, 3, 1);
    drive(0, 0, 3'b000, 1);
    chk("sat_cnt", 32'(evt_cnt), CMAX);
    chk("sat_state", 32'(mon_state), 1);

    // Randomized traffic, mostly repeating relations so commits are frequent
    last = 3'b001;
    for (int c = 0; c < 3000; c++) begin
      int pick;
      pick = $urandom_range(0, 9);
      if (pick < 6) s = last;
      else if (pick < 9) s = rels[$urandom_range(0, 2)];
      else s = bads[$urandom_range(0, 4)];
      if (is_rel(int'(s))) last = s;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, s, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 3'b000, 1);
    drive(0, 0, 3'b000, 1);
    drive(0, 0, 3'b000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
